mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access runs IDLE -> ACCESS -> RESP; a memory clear runs IDLE -> CLEAR.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [ADDR_BITS-1:0]   a_addr,
  input  logic [DATA_BITS-1:0]   a_wdata,
  input  logic [DATA_BITS/8-1:0] a_sel,
  output logic                   a_gnt,
  output logic                   a_ack,
  output logic [DATA_BITS-1:0]   a_rdata,
  input  logic                   b_req,
  input  logic                   b_we,
  input  logic [ADDR_BITS-1:0]   b_addr,
  input  logic [DATA_BITS-1:0]   b_wdata,
  input  logic [DATA_BITS/8-1:0] b_sel,
  output logic                   b_gnt,
  output logic                   b_ack,
  output logic [DATA_BITS-1:0]   b_rdata,
  input  logic                   mem_clear,
  output logic [ADDR_BITS-1:0]   m_addr,
  output logic [DATA_BITS-1:0]   m_data_in,
  output logic [DATA_BITS/8-1:0] m_sel,
  output logic                   m_str,
  output logic                   m_ld,
  output logic                   m_clr,
  input  logic [DATA_BITS-1:0]   m_data_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;

  // Port encoding for owner / rr_last: 0 = A, 1 = B.
  logic [1:0]             r_state;
  logic                   r_owner;
  logic                   r_rr_last;
  logic                   r_we;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [DATA_BITS-1:0]   r_wdata;
  logic [DATA_BITS/8-1:0] r_sel;
  logic                   r_a_gnt;
  logic                   r_b_gnt;
  logic                   r_a_ack;
  logic                   r_b_ack;

  logic w_any;
  logic w_win;
  logic w_in_access;

  // On a tie the port that did not win last time goes next.
  assign w_any       = a_req | b_req;
  assign w_win       = (a_req & b_req) ? ~r_rr_last : ~a_req;
  assign w_in_access = (r_state == S_ACCESS);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_a_gnt   <= 1'b0;
      r_b_gnt   <= 1'b0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
    end else begin
      r_a_gnt <= 1'b0;
      r_b_gnt <= 1'b0;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_clear) begin
            r_state <= S_CLEAR;
          end else if (w_any) begin
            r_state   <= S_ACCESS;
            r_owner   <= w_win;
            r_rr_last <= w_win;
            r_we      <= w_win ? b_we    : a_we;
            r_addr    <= w_win ? b_addr  : a_addr;
            r_wdata   <= w_win ? b_wdata : a_wdata;
            r_sel     <= w_win ? b_sel   : a_sel;
            r_a_gnt   <= ~w_win;
            r_b_gnt   <= w_win;
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
          r_a_ack <= ~r_owner;
          r_b_ack <= r_owner;
        end
        S_RESP:  r_state <= S_IDLE;
        S_CLEAR: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory command is only presented during ACCESS, so an async clear drops it at once.
  assign m_addr    = w_in_access ? r_addr  : '0;
  assign m_data_in = w_in_access ? r_wdata : '0;
  assign m_sel     = w_in_access ? r_sel   : '0;
  assign m_str     = w_in_access & r_we;
  assign m_ld      = w_in_access & ~r_we;
  assign m_clr     = (r_state == S_CLEAR);

  assign a_gnt   = r_a_gnt;
  assign b_gnt   = r_b_gnt;
  assign a_ack   = r_a_ack;
  assign b_ack   = r_b_ack;
  assign a_rdata = (r_a_ack && !r_we) ? m_data_out : '0;
  assign b_rdata = (r_b_ack && !r_we) ? m_data_out : '0;

endmodule
